// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - credit-based instruction fetch unit with redirect flush and stale-response drop
module fetch_unit #(
    parameter int                 ADDR_W      = 16,
    parameter int                 INSTR_BYTES = 2,
    parameter int                 DEPTH       = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redir_valid,
    input  logic [ADDR_W-1:0]        redir_addr,
    output logic                     mem_req_valid,
    output logic [ADDR_W-1:0]        mem_req_addr,
    input  logic                     mem_req_ready,
    input  logic                     mem_rsp_valid,
    input  logic [8*INSTR_BYTES-1:0] mem_rsp_data,
    output logic                     instr_valid,
    output logic [8*INSTR_BYTES-1:0] instr_data,
    output logic [ADDR_W-1:0]        instr_pc,
    input  logic                     instr_ready
);

    localparam int DATA_W = 8 * INSTR_BYTES;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INSTR_BYTES);
    localparam logic [CNT_W:0]    LIMIT = (CNT_W+1)'(DEPTH);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] exp_pc;
    logic [DATA_W-1:0] buf_data [DEPTH];
    logic [ADDR_W-1:0] buf_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  drop;

    logic [CNT_W:0]    credit_used;
    logic              fire;
    logic              push;
    logic              pop;
    logic              rsp_drop;
    logic [CNT_W-1:0]  inflight_next;
    logic [CNT_W-1:0]  count_next;

    // Credit covers both buffered entries and every outstanding request, stale or not.
    assign credit_used   = {1'b0, count} + {1'b0, inflight};
    assign mem_req_valid = reset && !redir_valid && (credit_used < LIMIT);
    assign mem_req_addr  = pc;
    assign fire          = mem_req_valid && mem_req_ready;

    assign instr_valid = (count != '0);
    assign instr_data  = buf_data[rd_ptr];
    assign instr_pc    = buf_pc[rd_ptr];

    assign rsp_drop = mem_rsp_valid && (drop != '0);
    assign push     = mem_rsp_valid && (drop == '0) && !redir_valid;
    assign pop      = instr_valid && instr_ready && !redir_valid;

    always_comb begin
        inflight_next = inflight + CNT_W'(fire) - CNT_W'(mem_rsp_valid);
        count_next    = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            exp_pc   <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= RESET_PC;
            end
        end else begin
            inflight <= inflight_next;
            if (redir_valid) begin
                // Everything still outstanding after this edge belongs to the old stream.
                pc     <= redir_addr;
                exp_pc <= redir_addr;
                drop   <= inflight_next;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (fire) begin
                    pc <= pc + STEP;
                end
                if (rsp_drop) begin
                    drop <= drop - CNT_W'(1);
                end
                if (push) begin
                    buf_data[wr_ptr] <= mem_rsp_data;
                    buf_pc[wr_ptr]   <= exp_pc;
                    wr_ptr           <= wr_ptr + PTR_W'(1);
                    exp_pc           <= exp_pc + STEP;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized transaction-level check of fetch_unit against a queue-based model
module tb_fetch_unit;

    localparam int ADDR_W = 16;
    localparam int IB     = 2;
    localparam int DEPTH  = 4;
    localparam int DW     = 8 * IB;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    logic              clk = 1'b0;
    logic              reset;
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_addr;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [DW-1:0]     mem_rsp_data;
    logic              instr_valid;
    logic [DW-1:0]     instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    fetch_unit #(
        .ADDR_W(ADDR_W), .INSTR_BYTES(IB), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .reset(reset),
        .redir_valid(redir_valid), .redir_addr(redir_addr),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: memory holds requests in order tagged by stream epoch; buffer holds expected instructions.
    logic [ADDR_W-1:0] mq_addr[$];
    int                mq_epoch[$];
    logic [ADDR_W-1:0] bq_pc[$];
    logic [DW-1:0]     bq_data[$];
    logic [ADDR_W-1:0] m_pc;
    int                epoch;
    int                n_fires;
    int                n_retired;

    int                p_mready, p_rsp, p_iready, p_redir;
    bit                use_target;
    logic [ADDR_W-1:0] target;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = {a, a} ^ 32'hA5C3_5A3C;
        return w[DW-1:0];
    endfunction

    task automatic cycle();
        logic              rsp;
        logic              exp_valid;
        logic              fire;
        logic [ADDR_W-1:0] ra;
        int                re;
        mem_req_ready = ($urandom_range(99) < p_mready);
        instr_ready   = ($urandom_range(99) < p_iready);
        redir_valid   = ($urandom_range(99) < p_redir);
        redir_addr    = use_target ? target : (ADDR_W'($urandom) & ~ADDR_W'(IB - 1));
        rsp           = (mq_addr.size() != 0) && ($urandom_range(99) < p_rsp);
        mem_rsp_valid = rsp;
        mem_rsp_data  = rsp ? mem_word(mq_addr[0]) : DW'($urandom);
        #1;
        exp_valid = ((bq_pc.size() + mq_addr.size()) < DEPTH) && !redir_valid;
        check("mem_req_valid", 32'(mem_req_valid), 32'(exp_valid));
        if (exp_valid) check("mem_req_addr", 32'(mem_req_addr), 32'(m_pc));
        check("instr_valid", 32'(instr_valid), 32'(bq_pc.size() != 0));
        if (bq_pc.size() != 0) begin
            check("instr_pc", 32'(instr_pc), 32'(bq_pc[0]));
            check("instr_data", 32'(instr_data), 32'(bq_data[0]));
        end
        fire = exp_valid && mem_req_ready;
        ra = '0;
        re = -1;
        if (rsp) begin
            ra = mq_addr.pop_front();
            re = mq_epoch.pop_front();
        end
        if (redir_valid) begin
            bq_pc.delete();
            bq_data.delete();
            epoch++;
            m_pc = redir_addr;
        end else begin
            if (bq_pc.size() != 0 && instr_ready) begin
                void'(bq_pc.pop_front());
                void'(bq_data.pop_front());
                n_retired++;
            end
            if (rsp && re == epoch) begin
                bq_pc.push_back(ra);
                bq_data.push_back(mem_word(ra));
            end
            if (fire) begin
                mq_addr.push_back(mem_req_addr);
                mq_epoch.push_back(epoch);
                m_pc = m_pc + ADDR_W'(IB);
                n_fires++;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_knobs(input int mr, input int rs, input int ir, input int rd);
        p_mready = mr; p_rsp = rs; p_iready = ir; p_redir = rd;
        use_target = 1'b0;
    endtask

    task automatic do_redirect(input logic [ADDR_W-1:0] a);
        int sv;
        sv = p_redir;
        p_redir = 100; use_target = 1'b1; target = a;
        cycle();
        p_redir = sv; use_target = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redir_valid = 1'b0; redir_addr = '0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; instr_ready = 1'b0;
        #1;
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'(RESET_PC));
        check("rst_instr_data", 32'(instr_data), 32'd0);
        mq_addr.delete(); mq_epoch.delete(); bq_pc.delete(); bq_data.delete();
        m_pc = RESET_PC; epoch = 0; n_fires = 0; n_retired = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("first_req_valid", 32'(mem_req_valid), 32'd1);
        check("first_req_addr", 32'(mem_req_addr), 32'(RESET_PC));
    endtask

    initial begin
        set_knobs(100, 100, 100, 0);
        do_reset();

        // Streaming: one instruction per cycle after a two-cycle fill.
        repeat (20) cycle();
        check("stream_retired", 32'(n_retired), 32'd18);

        // Backpressure: credit caps outstanding work at DEPTH.
        do_reset();
        set_knobs(100, 100, 0, 0);
        repeat (10) cycle();
        check("bp_fires", 32'(n_fires), 32'(DEPTH));
        check("bp_next_pc", 32'(m_pc), 32'h8);
        set_knobs(100, 100, 100, 0);
        repeat (10) cycle();

        // Redirect with requests in flight, then a wrapping redirect.
        do_reset();
        set_knobs(100, 0, 100, 0);
        repeat (2) cycle();
        set_knobs(100, 100, 100, 0);
        do_redirect(16'h0100);
        repeat (8) cycle();
        do_redirect(16'hFFFE);
        n_retired = 0;
        repeat (8) cycle();
        check("wrap_retired", 32'(n_retired), 32'd6);

        // Back-to-back redirects with responses pending.
        set_knobs(100, 30, 50, 0);
        repeat (4) cycle();
        do_redirect(16'h1230);
        do_redirect(16'h4560);
        do_redirect(16'h7770);
        set_knobs(100, 60, 100, 0);
        repeat (15) cycle();

        // Random traffic, with occasional mid-stream resets.
        for (int seg = 0; seg < 6; seg++) begin
            set_knobs($urandom_range(30, 100), $urandom_range(20, 100),
                      $urandom_range(10, 100), $urandom_range(0, 12));
            repeat (400) cycle();
            set_knobs(100, 100, 0, 0);
            repeat (6) cycle();
            do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
